snax_hwpe_tcdm_bridge: RTL

Parametrised successor bridge that converts an HWPE TCDM slave port (`hwpe_stream_intf_tcdm`, narrow word, active-low `wen`) into a Snitch TCDM reqrsp master port of equal or wider data width. It has two buffers:

- a request FIFO of configurable depth;
- a read-tracking FIFO bounded by an outstanding-read limit.

It performs full byte-lane strobe, write-data and read-data steering, and grants combinationally. It sits between a SNAX accelerator's HWPE streamer and a cluster TCDM interconnect port.

---
 rtl/snax_hwpe_bridge_pkg.sv | 57 +++++
 rtl/hwpe_stream_intf_tcdm.sv | 18 +
 rtl/snax_hwpe_lane_steer.sv | 36 +++
 rtl/snax_hwpe_tcdm_bridge.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/snax_hwpe_bridge_pkg.sv
// Shared definitions for the HWPE-to-Snitch TCDM bridge.
//   PerfCntWidth      : width of the performance counter ports.
//   lane_idx_width()  : bits needed to index a data lane (at least 1).
//   amo_op_e/AMONone  : reqrsp atomic opcode, re-exported for the q.amo field.
//   tcdm_*_default_t  : reqrsp request/response types at the default widths
//                       (48-bit address, 64-bit data), used when the parent
//                       does not override the type parameters.
// Optional feature macro used by this slice: SNAX_HWPE_BRIDGE_PERF_EN.
package snax_hwpe_bridge_pkg;

  localparam int unsigned PerfCntWidth = 32;

  typedef enum logic [3:0] {
    AMONone = 4'h0,
    AMOSwap = 4'h1,
    AMOAdd  = 4'h2,
    AMOAnd  = 4'h3,
    AMOOr   = 4'h4,
    AMOXor  = 4'h5,
    AMOMax  = 4'h6,
    AMOMaxu = 4'h7,
    AMOMin  = 4'h8,
    AMOMinu = 4'h9,
    AMOLR   = 4'hA,
    AMOSC   = 4'hB
  } amo_op_e;

  function automatic int unsigned lane_idx_width(input int unsigned num_lanes);
    return (num_lanes > 1) ? $clog2(num_lanes) : 1;
  endfunction

  typedef struct packed {
    logic [47:0] addr;
    logic        write;
    amo_op_e     amo;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [0:0]  user;
  } tcdm_req_chan_default_t;

  typedef struct packed {
    logic [63:0] data;
  } tcdm_rsp_chan_default_t;

  typedef struct packed {
    tcdm_req_chan_default_t q;
    logic                   q_valid;
    logic                   p_ready;
  } tcdm_req_default_t;

  typedef struct packed {
    tcdm_rsp_chan_default_t p;
    logic                   p_valid;
    logic                   q_ready;
  } tcdm_rsp_default_t;

endpackage

// File: rtl/hwpe_stream_intf_tcdm.sv
// HWPE TCDM port: narrow word, active-low wen, 32-bit byte address.
//   master : drives req/add/wen/be/data, receives gnt/r_data/r_valid.
//   slave  : the mirror image.
interface hwpe_stream_intf_tcdm #(
  parameter int unsigned DW = 32
);
  logic          req;
  logic          gnt;
  logic [31:0]   add;
  logic          wen;
  logic [DW/8-1:0] be;
  logic [DW-1:0] data;
  logic [DW-1:0] r_data;
  logic          r_valid;

  modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
  modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

// File: rtl/snax_hwpe_lane_steer.sv
// Combinational byte-lane steering between one HWPE word and a wide TCDM word.
//   wr_lane_i/be_i/wdata_i : lane, byte enables and data of the outgoing request
//   strb_o                 : be_i placed in the selected lane, zeros elsewhere
//   wdata_o                : wdata_i replicated into every lane
//   rd_lane_i/rdata_i      : lane of the returning read and the wide read data
//   rdata_o                : the selected lane of rdata_i
import snax_hwpe_bridge_pkg::*;

module snax_hwpe_lane_steer #(
  parameter  int unsigned NumLanes      = 2,
  parameter  int unsigned HwpeDataWidth = 32,
  localparam int unsigned LaneW         = lane_idx_width(NumLanes),
  localparam int unsigned HwpeBeW       = HwpeDataWidth / 8
) (
  input  logic [LaneW-1:0]                  wr_lane_i,
  input  logic [HwpeBeW-1:0]                be_i,
  input  logic [HwpeDataWidth-1:0]          wdata_i,
  output logic [NumLanes*HwpeBeW-1:0]       strb_o,
  output logic [NumLanes*HwpeDataWidth-1:0] wdata_o,
  input  logic [LaneW-1:0]                  rd_lane_i,
  input  logic [NumLanes*HwpeDataWidth-1:0] rdata_i,
  output logic [HwpeDataWidth-1:0]          rdata_o
);

  always_comb begin
    strb_o  = '0;
    wdata_o = '0;
    rdata_o = '0;
    for (int unsigned i = 0; i < NumLanes; i++) begin
      wdata_o[i*HwpeDataWidth +: HwpeDataWidth] = wdata_i;
      if (wr_lane_i == LaneW'(i)) strb_o[i*HwpeBeW +: HwpeBeW] = be_i;
      if (rd_lane_i == LaneW'(i)) rdata_o = rdata_i[i*HwpeDataWidth +: HwpeDataWidth];
    end
  end

endmodule

// File: rtl/snax_hwpe_tcdm_bridge.sv
// HWPE TCDM slave port to Snitch reqrsp TCDM master port bridge.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   tcdm_req_o        : reqrsp request (q, q_valid, p_ready)
//   tcdm_rsp_i        : reqrsp response (p, p_valid, q_ready)
//   hwpe_tcdm_slave   : HWPE port; gnt is combinational, r_valid/r_data are
//                       combinational from p_valid
//   perf_stall_o      : saturating count of cycles with req=1 and gnt=0
//   perf_reads_o      : saturating count of completed reads
// Macro SNAX_HWPE_BRIDGE_PERF_EN enables the counters; otherwise both are 0.
import snax_hwpe_bridge_pkg::*;

module snax_hwpe_tcdm_bridge #(
  parameter int unsigned AddrWidth      = 48,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned HwpeDataWidth  = 32,
  parameter int unsigned ReqDepth       = 8,
  parameter int unsigned MaxOutstanding = 8,
  parameter type         tcdm_req_t     = tcdm_req_default_t,
  parameter type         tcdm_rsp_t     = tcdm_rsp_default_t
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  output tcdm_req_t               tcdm_req_o,
  input  tcdm_rsp_t               tcdm_rsp_i,
  hwpe_stream_intf_tcdm.slave     hwpe_tcdm_slave,
  output logic [PerfCntWidth-1:0] perf_stall_o,
  output logic [PerfCntWidth-1:0] perf_reads_o
);

  localparam int unsigned NumLanes = DataWidth / HwpeDataWidth;
  localparam int unsigned LaneW    = lane_idx_width(NumLanes);
  localparam int unsigned HwpeBeW  = HwpeDataWidth / 8;
  localparam int unsigned LaneLsb  = $clog2(HwpeDataWidth / 8);
  localparam int unsigned ReqCntW  = $clog2(ReqDepth + 1);
  localparam int unsigned ReqPtrW  = $clog2(ReqDepth);
  localparam int unsigned RdCntW   = $clog2(MaxOutstanding + 1);
  localparam int unsigned RdPtrW   = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  typedef struct packed {
    logic [31:0]              addr;
    logic                     write;
    logic [LaneW-1:0]         lane;
    logic [HwpeBeW-1:0]       be;
    logic [HwpeDataWidth-1:0] data;
  } req_entry_t;

  // Both buffers behave as non-fall-through FIFOs: a pushed entry is
  // visible at the head one cycle later, and a pop never frees a slot for
  // a push in the same cycle.
  req_entry_t       req_mem_q [ReqDepth];
  logic [ReqPtrW-1:0] req_wptr_q, req_wptr_d, req_rptr_q, req_rptr_d;
  logic [ReqCntW-1:0] req_cnt_q, req_cnt_d;

  logic [LaneW-1:0]  rd_mem_q [MaxOutstanding];
  logic [RdPtrW-1:0] rd_wptr_q, rd_wptr_d, rd_rptr_q, rd_rptr_d;
  logic [RdCntW-1:0] rd_cnt_q, rd_cnt_d;

  logic       req_full, req_empty, gnt, rd_push, req_pop, rd_pop;
  logic [LaneW-1:0] in_lane;
  req_entry_t in_entry, req_head;
  logic [NumLanes*HwpeBeW-1:0]       wide_strb;
  logic [NumLanes*HwpeDataWidth-1:0] wide_wdata;
  logic [HwpeDataWidth-1:0]          narrow_rdata;

  if (NumLanes > 1) begin : g_lane
    always_comb in_lane = hwpe_tcdm_slave.add[LaneLsb +: LaneW];
  end else begin : g_nolane
    always_comb in_lane = '0;
  end

  always_comb begin
    req_full  = (req_cnt_q == ReqCntW'(ReqDepth));
    req_empty = (req_cnt_q == '0);
    gnt       = hwpe_tcdm_slave.req & ~req_full &
                (~hwpe_tcdm_slave.wen | (rd_cnt_q < RdCntW'(MaxOutstanding)));
    rd_push   = gnt & hwpe_tcdm_slave.wen;
    req_pop   = ~req_empty & tcdm_rsp_i.q_ready;
    // Responses with nothing outstanding are dropped.
    rd_pop    = tcdm_rsp_i.p_valid & (rd_cnt_q != '0);
    req_head  = req_mem_q[req_rptr_q];

    in_entry.addr  = hwpe_tcdm_slave.add;
    in_entry.write = ~hwpe_tcdm_slave.wen;
    in_entry.lane  = in_lane;
    in_entry.be    = hwpe_tcdm_slave.be;
    in_entry.data  = hwpe_tcdm_slave.data;
  end

  always_comb begin
    req_wptr_d = req_wptr_q;
    req_rptr_d = req_rptr_q;
    req_cnt_d  = req_cnt_q;
    if (gnt)     req_wptr_d = (req_wptr_q == ReqPtrW'(ReqDepth - 1)) ? '0 : req_wptr_q + ReqPtrW'(1);
    if (req_pop) req_rptr_d = (req_rptr_q == ReqPtrW'(ReqDepth - 1)) ? '0 : req_rptr_q + ReqPtrW'(1);
    case ({gnt, req_pop})
      2'b10:   req_cnt_d = req_cnt_q + ReqCntW'(1);
      2'b01:   req_cnt_d = req_cnt_q - ReqCntW'(1);
      default: req_cnt_d = req_cnt_q;
    endcase

    rd_wptr_d = rd_wptr_q;
    rd_rptr_d = rd_rptr_q;
    rd_cnt_d  = rd_cnt_q;
    if (rd_push) rd_wptr_d = (rd_wptr_q == RdPtrW'(MaxOutstanding - 1)) ? '0 : rd_wptr_q + RdPtrW'(1);
    if (rd_pop)  rd_rptr_d = (rd_rptr_q == RdPtrW'(MaxOutstanding - 1)) ? '0 : rd_rptr_q + RdPtrW'(1);
    case ({rd_push, rd_pop})
      2'b10:   rd_cnt_d = rd_cnt_q + RdCntW'(1);
      2'b01:   rd_cnt_d = rd_cnt_q - RdCntW'(1);
      default: rd_cnt_d = rd_cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_wptr_q <= '0;
      req_rptr_q <= '0;
      req_cnt_q  <= '0;
      rd_wptr_q  <= '0;
      rd_rptr_q  <= '0;
      rd_cnt_q   <= '0;
    end else begin
      req_wptr_q <= req_wptr_d;
      req_rptr_q <= req_rptr_d;
      req_cnt_q  <= req_cnt_d;
      rd_wptr_q  <= rd_wptr_d;
      rd_rptr_q  <= rd_rptr_d;
      rd_cnt_q   <= rd_cnt_d;
    end
  end

  // Storage needs no reset: entries are only observed through the counters.
  always_ff @(posedge clk_i) begin
    if (gnt)     req_mem_q[req_wptr_q] <= in_entry;
    if (rd_push) rd_mem_q[rd_wptr_q]   <= in_lane;
  end

  snax_hwpe_lane_steer #(
    .NumLanes      (NumLanes),
    .HwpeDataWidth (HwpeDataWidth)
  ) i_lane_steer (
    .wr_lane_i (req_head.lane),
    .be_i      (req_head.be),
    .wdata_i   (req_head.data),
    .strb_o    (wide_strb),
    .wdata_o   (wide_wdata),
    .rd_lane_i (rd_mem_q[rd_rptr_q]),
    .rdata_i   (tcdm_rsp_i.p.data),
    .rdata_o   (narrow_rdata)
  );

  always_comb begin
    tcdm_req_o         = '0;
    tcdm_req_o.q_valid = ~req_empty;
    tcdm_req_o.q.addr  = AddrWidth'(req_head.addr);
    tcdm_req_o.q.write = req_head.write;
    tcdm_req_o.q.amo   = AMONone;
    tcdm_req_o.q.data  = wide_wdata;
    tcdm_req_o.q.strb  = wide_strb;
    tcdm_req_o.q.user  = '0;
    tcdm_req_o.p_ready = 1'b1;

    hwpe_tcdm_slave.gnt     = gnt;
    hwpe_tcdm_slave.r_valid = rd_pop;
    hwpe_tcdm_slave.r_data  = narrow_rdata;
  end

`ifdef SNAX_HWPE_BRIDGE_PERF_EN
  logic [PerfCntWidth-1:0] stall_q, stall_d, reads_q, reads_d;

  always_comb begin
    stall_d = stall_q;
    reads_d = reads_q;
    if (hwpe_tcdm_slave.req & ~gnt & (stall_q != '1)) stall_d = stall_q + PerfCntWidth'(1);
    if (rd_pop & (reads_q != '1))                    reads_d = reads_q + PerfCntWidth'(1);
    perf_stall_o = stall_q;
    perf_reads_o = reads_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
      reads_q <= '0;
    end else begin
      stall_q <= stall_d;
      reads_q <= reads_d;
    end
  end
`else
  always_comb begin
    perf_stall_o = '0;
    perf_reads_o = '0;
  end
`endif

  spurious_rsp_a: assert property (@(posedge clk_i) disable iff (rst_i)
    tcdm_rsp_i.p_valid |-> (rd_cnt_q != '0));

endmodule
